spi_master_shifter: RTL and testbench
=====================================

Name: spi_master_shifter

Overview:
- SPI master shift engine directly downstream of the APB SPI slave interface.
- Consumes send_data, mosi_data and the CR1/BR configuration fields from that interface.
- Generates SCLK, SS and MOSI, and shifts in MISO.
- Returns the received byte on miso_data with a one-cycle receive_data strobe, and holds tip high while a transfer is in progress.

Parameters:
DATA_WIDTH, 8, bits per frame; the bit counter covers 2*DATA_WIDTH SCLK edges

Ports:
PCLK  input  1  system clock; all logic on rising edge
PRESET  input  1  synchronous reset, active high
send_data  input  1  transfer request; sampled only in IDLE
mosi_data  input  DATA_WIDTH  byte to transmit; latched on accept
mstr  input  1  master enable; requests ignored when 0
cpol  input  1  SCLK idle level
cpha  input  1  0: sample on odd edges; 1: sample on even edges
lsbfe  input  1  1: LSB first (tx and rx); 0: MSB first
sppr  input  3  baud prescale
spr  input  3  baud rate select
spi_mode  input  2  00 run, 01 wait, 10 stop
miso  input  1  serial in; already synchronous to PCLK
sclk  output  1  SPI clock
mosi  output  1  serial out
ss  output  1  slave select, active low
tip  output  1  transfer in progress
receive_data  output  1  one-cycle strobe; miso_data is valid
miso_data  output  DATA_WIDTH  last received frame

Behaviour:
- Reset (PRESET=1 at a PCLK edge), including mid-transfer:
  - State IDLE; sclk=0, mosi=0, ss=1, tip=0, receive_data=0, miso_data=0.
  - Counters and shift registers cleared.
  - An in-flight frame is discarded with no strobe.
- Half period H = (sppr+1) * 2^spr PCLK cycles, giving SCLK divisor 2H. Range: H=1 (2 cycles) up to H=1024 (divisor 2048). The half-period counter is 11 bits.
- Accept condition: IDLE and send_data=1 and mstr=1 and spi_mode!=10.
  - On the accepting edge: latch mosi_data, cpol, cpha, lsbfe and H. Mid-frame changes to these inputs have no effect.
  - send_data is ignored outside IDLE (no queueing).
  - Accept when spi_mode=11 is treated as run.
- State machine:
  - IDLE: sclk=latched-or-live cpol (tracks the cpol input), ss=1, tip=0, mosi=0.
  - LEAD: entered the cycle after accept. ss=0, tip=1. Lasts H cycles (setup time).
    - If cpha=0, mosi presents the first bit on entry to LEAD.
  - XFER: 2*DATA_WIDTH SCLK toggles, one every H cycles. The first toggle occurs H cycles after entering XFER.
    - cpha=0: sample miso on edges 1,3,…,15; shift/drive the next bit on edges 2,4,…,14.
    - cpha=1: drive a bit on edges 1,3,…,15; sample on edges 2,4,…,16.
    - Sampling uses the miso value present at the PCLK edge that produces the SCLK edge.
  - TRAIL: after the final toggle, sclk=cpol and ss stays 0 for H cycles.
  - Then IDLE with ss=1, tip=0, and on that same cycle: receive_data=1 for exactly one cycle and miso_data updated.
- Latency: accept at edge N → ss low at N+1 → receive_data high at N+1+(2*DATA_WIDTH+2)*H. For DATA_WIDTH=8 and H=1 this is N+19.
- Bit order:
  - lsbfe=0: tx bit7 first; rx bits fill bit7 first.
  - lsbfe=1: tx bit0 first; rx bits fill bit0 first.
- Stop freeze: while spi_mode=10 in LEAD, XFER or TRAIL:
  - Half-period counter, edge counter, sclk, mosi and ss are all held; tip stays 1.
  - Resumes from the exact point when spi_mode leaves 10.
  - Run (00) and wait (01) behave identically.
- mstr falling mid-frame does not abort; the frame completes.
- miso_data holds its value between transfers; it changes only on a receive_data cycle.

Test Plan:
1. Mode 0 (cpol=0, cpha=0, lsbfe=0, sppr=0, spr=0), mosi_data=0xA5, miso drives 0x3C MSB-first → mosi serialises 1,0,1,0,0,1,0,1; sclk rises at sample edges; receive_data pulses at N+19; miso_data=0x3C; ss low N+1..N+18.
2. cpol=1, cpha=1, lsbfe=1, mosi_data=0x81, miso drives 0xF0 LSB-first → sclk idles high; mosi drives bits on edges 1,3,…,15 as 1,0,0,0,0,0,0,1; miso_data=0xF0.
3. sppr=1, spr=1 (H=4): → sclk period 8 PCLK; receive_data at N+1+72; reprogramming spr mid-frame does not change timing.
4. send_data pulsed again at mid-XFER → ignored, exactly one receive_data. mstr=0 with send_data → stays IDLE, ss=1, tip=0.
5. spi_mode=10 for 20 cycles after edge 5 → sclk, ss, mosi frozen, tip=1; completion delayed by exactly 20 cycles; received byte correct.
6. PRESET=1 at edge 9 of a frame → next cycle ss=1, sclk=0, tip=0, no receive_data; miso_data=0; a subsequent transfer completes normally.

Source files
------------

// File: rtl/spi_master_shifter_if.sv
// Signal bundle between the APB SPI register block and the SPI master shift engine.
// The master modport is the shift engine's view; slave is the register-block/bench view.
interface spi_master_shifter_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  send_data;
    logic [DATA_WIDTH-1:0] mosi_data;
    logic                  mstr;
    logic                  cpol;
    logic                  cpha;
    logic                  lsbfe;
    logic [2:0]            sppr;
    logic [2:0]            spr;
    logic [1:0]            spi_mode;
    logic                  miso;
    logic                  sclk;
    logic                  mosi;
    logic                  ss;
    logic                  tip;
    logic                  receive_data;
    logic [DATA_WIDTH-1:0] miso_data;

    // A frame starts when send_data is seen high in IDLE with mstr=1 and spi_mode!=10;
    // there is no ready back-pressure, requests outside IDLE are dropped.
    modport master (
        input  send_data, mosi_data, mstr, cpol, cpha, lsbfe, sppr, spr, spi_mode, miso,
        output sclk, mosi, ss, tip, receive_data, miso_data
    );

    modport slave (
        output send_data, mosi_data, mstr, cpol, cpha, lsbfe, sppr, spr, spi_mode, miso,
        input  sclk, mosi, ss, tip, receive_data, miso_data
    );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master shift engine: generates SCLK/SS/MOSI from a latched frame configuration,
// shifts MISO in, and strobes receive_data with the received frame on completion.
module spi_master_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    spi_master_shifter_if.master bus,
    output logic [1:0]           o_dbg_state
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int EW = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
    localparam logic [EW-1:0] ONE_E     = EW'(1);
    localparam logic [BW-1:0] TOP_BIT   = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_t;

    state_t                r_state, w_next;
    logic [10:0]           r_cnt, r_half, w_half;
    logic [3:0]            w_presc;
    logic [EW-1:0]         r_edge, w_edge_num, w_edge_m1;
    logic [DATA_WIDTH-1:0] r_tx, r_rx, r_miso_data;
    logic                  r_cpol, r_cpha, r_lsbfe;
    logic                  r_sclk, r_mosi, r_rx_valid;
    logic                  w_accept, w_frozen, w_tick, w_last_edge;
    logic                  w_drive, w_sample, w_ss, w_tip;
    logic [BW-1:0]         w_drive_idx, w_sample_idx, w_tx_pos, w_rx_pos;

    // Half SCLK period H = (sppr+1) * 2^spr, 1..1024 PCLK cycles.
    assign w_presc = {1'b0, bus.sppr} + 4'd1;
    assign w_half  = {7'd0, w_presc} << bus.spr;

    assign w_accept    = (r_state == ST_IDLE) && bus.send_data && bus.mstr && (bus.spi_mode != 2'b10);
    assign w_frozen    = (r_state != ST_IDLE) && (bus.spi_mode == 2'b10);
    assign w_tick      = !w_frozen && (r_cnt == (r_half - 11'd1));
    assign w_last_edge = (r_edge == LAST_EDGE);

    // r_edge counts SCLK edges already produced, so the edge about to happen is r_edge+1.
    // Odd edges are even r_edge values; cpha selects which parity samples and which drives.
    assign w_edge_num   = r_edge + ONE_E;
    assign w_edge_m1    = r_edge - ONE_E;
    assign w_drive      = r_cpha ? ~r_edge[0] : (r_edge[0] && !w_last_edge);
    assign w_sample     = r_cpha ? r_edge[0] : ~r_edge[0];
    assign w_drive_idx  = r_cpha ? BW'(r_edge >> 1) : BW'(w_edge_num >> 1);
    assign w_sample_idx = r_cpha ? BW'(w_edge_m1 >> 1) : BW'(r_edge >> 1);
    assign w_tx_pos     = r_lsbfe ? w_drive_idx : (TOP_BIT - w_drive_idx);
    assign w_rx_pos     = r_lsbfe ? w_sample_idx : (TOP_BIT - w_sample_idx);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ss   = 1'b0;
        w_tip  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_ss  = 1'b1;
                w_tip = 1'b0;
                if (w_accept) begin
                    w_next = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (w_tick) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_tick && w_last_edge) begin
                    w_next = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (w_tick) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt       <= '0;
            r_half      <= 11'd1;
            r_edge      <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_miso_data <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_lsbfe     <= 1'b0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_sclk <= bus.cpol;
                r_mosi <= 1'b0;
                r_cnt  <= '0;
                r_edge <= '0;
                if (w_accept) begin
                    r_tx    <= bus.mosi_data;
                    r_rx    <= '0;
                    r_cpol  <= bus.cpol;
                    r_cpha  <= bus.cpha;
                    r_lsbfe <= bus.lsbfe;
                    r_half  <= w_half;
                    if (!bus.cpha) begin
                        r_mosi <= bus.lsbfe ? bus.mosi_data[0] : bus.mosi_data[DATA_WIDTH-1];
                    end
                end
            end else if (!w_frozen) begin
                r_cnt <= w_tick ? 11'd0 : (r_cnt + 11'd1);
                if (w_tick && (r_state == ST_XFER)) begin
                    r_sclk <= w_last_edge ? r_cpol : ~r_sclk;
                    r_edge <= w_edge_num;
                    if (w_drive) begin
                        r_mosi <= r_tx[w_tx_pos];
                    end
                    if (w_sample) begin
                        r_rx[w_rx_pos] <= bus.miso;
                    end
                end
                if (w_tick && (r_state == ST_TRAIL)) begin
                    r_rx_valid  <= 1'b1;
                    r_miso_data <= r_rx;
                    r_mosi      <= 1'b0;
                end
            end
        end
    end

    assign bus.sclk         = r_sclk;
    assign bus.mosi         = r_mosi;
    assign bus.ss           = w_ss;
    assign bus.tip          = w_tip;
    assign bus.receive_data = r_rx_valid;
    assign bus.miso_data    = r_miso_data;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: table of frame configurations, a behavioural SPI slave,
// and a scoreboard of expected received bytes, latencies and MOSI bytes.
module tb_spi_master_shifter;
    localparam int DW = 8;

    typedef struct {
        logic          cpol;
        logic          cpha;
        logic          lsbfe;
        logic [2:0]    sppr;
        logic [2:0]    spr;
        logic [DW-1:0] tx;
        logic [DW-1:0] rx;
        logic [DW-1:0] exp_rx;
        int            exp_lat;
    } vec_t;

    logic       pclk = 1'b0;
    logic       preset;
    logic [1:0] dbg_state;

    always #5 pclk = ~pclk;

    spi_master_shifter_if #(.DATA_WIDTH(DW)) bus ();

    spi_master_shifter #(.DATA_WIDTH(DW)) u_dut (
        .PCLK        (pclk),
        .PRESET      (preset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_accept = 0;
    int n_strobes = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mosi_q[$];
    int            lat_q[$];

    // Slave model state
    logic          s_miso = 1'b0;
    logic          s_cpol = 1'b0;
    logic          s_cpha = 1'b0;
    logic          s_lsbfe = 1'b0;
    logic [DW-1:0] s_rx = '0;
    logic [DW-1:0] s_mosi_cap = '0;
    int            s_edges = 0;
    int            s_ss_low = 0;
    logic          s_prev_sclk = 1'b0;
    logic          s_prev_ss = 1'b1;
    logic          prev_rv = 1'b0;

    assign bus.miso = s_miso;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int bpos(input int idx);
        return s_lsbfe ? idx : (DW - 1 - idx);
    endfunction

    // SPI slave + completion monitor, evaluated away from the active PCLK edge.
    always @(negedge pclk) begin
        int   k;
        int   lat;
        logic e;
        if (prev_rv) chk("strobe_width", bus.receive_data, 0);
        if (bus.receive_data) begin
            n_strobes++;
            if (exp_q.size() == 0) begin
                chk("strobe_expected", bus.receive_data, 0);
            end else begin
                lat = lat_q.pop_front();
                chk("miso_data", bus.miso_data, exp_q.pop_front());
                chk("latency", cyc - t_accept, lat);
                chk("ss_low_cycles", s_ss_low, lat);
                chk("mosi_serial", s_mosi_cap, mosi_q.pop_front());
                chk("edge_count", s_edges, 2 * DW);
                chk("done_ss", bus.ss, 1);
                chk("done_tip", bus.tip, 0);
                chk("done_mosi", bus.mosi, 0);
            end
        end
        prev_rv = bus.receive_data;

        if (!bus.ss && s_prev_ss) begin
            s_edges    = 0;
            s_ss_low   = 0;
            s_mosi_cap = '0;
            if (!s_cpha) s_miso = s_rx[bpos(0)];
        end
        if (!bus.ss) begin
            s_ss_low++;
            if (bus.sclk !== s_prev_sclk) begin
                k = s_edges + 1;
                s_edges = k;
                if (k == 1) begin
                    e = ~s_cpol;
                    chk("first_edge_dir", bus.sclk, e);
                end
                if (s_cpha ? (k % 2 == 0) : (k % 2 == 1))
                    s_mosi_cap[bpos(s_cpha ? (k / 2 - 1) : ((k - 1) / 2))] = bus.mosi;
                if (!s_cpha && (k % 2 == 0) && (k < 2 * DW)) s_miso = s_rx[bpos(k / 2)];
                if (s_cpha && (k % 2 == 1)) s_miso = s_rx[bpos((k - 1) / 2)];
            end
        end
        s_prev_sclk = bus.sclk;
        s_prev_ss   = bus.ss;
    end

    task automatic start_frame(input vec_t v, input int extra);
        logic first_bit;
        @(negedge pclk);
        bus.cpol      = v.cpol;
        bus.cpha      = v.cpha;
        bus.lsbfe     = v.lsbfe;
        bus.sppr      = v.sppr;
        bus.spr       = v.spr;
        bus.mosi_data = v.tx;
        bus.mstr      = 1'b1;
        bus.spi_mode  = 2'b00;
        s_cpol  = v.cpol;
        s_cpha  = v.cpha;
        s_lsbfe = v.lsbfe;
        s_rx    = v.rx;
        @(negedge pclk);
        chk("idle_sclk", bus.sclk, v.cpol);
        chk("idle_ss", bus.ss, 1);
        exp_q.push_back(v.exp_rx);
        lat_q.push_back(v.exp_lat + extra);
        mosi_q.push_back(v.tx);
        bus.send_data = 1'b1;
        @(posedge pclk);
        #1;
        t_accept = cyc;
        chk("lead_ss", bus.ss, 0);
        chk("lead_tip", bus.tip, 1);
        chk("lead_sclk", bus.sclk, v.cpol);
        if (!v.cpha) begin
            first_bit = v.lsbfe ? v.tx[0] : v.tx[DW-1];
            chk("lead_mosi", bus.mosi, first_bit);
        end
        @(negedge pclk);
        bus.send_data = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge pclk);
        chk("frame_done", exp_q.size(), 0);
        exp_q.delete();
        lat_q.delete();
        mosi_q.delete();
        @(negedge pclk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        vec_t       v;
        logic [7:0] t1, r1, t2, r2;
        logic [7:0] snap_sclk, snap_ss, snap_mosi;
        int         n0;

        t1 = 8'($urandom_range(0, 255));
        r1 = 8'($urandom_range(0, 255));
        t2 = 8'($urandom_range(0, 255));
        r2 = 8'($urandom_range(0, 255));
        //          cpol  cpha  lsbfe sppr  spr   tx     rx     exp_rx lat
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hA5, 8'h3C, 8'h3C, 18};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 8'h81, 8'hF0, 8'hF0, 18};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 8'h5A, 8'hC3, 8'hC3, 72};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 8'h96, 8'h69, 8'h69, 54};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd2, 8'hFF, 8'h00, 8'h00, 72};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 8'h00, 8'hFF, 8'hFF, 144};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 3'd1, 3'd0, t1,    r1,    r1,    36};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd1, t2,    r2,    r2,    36};

        preset        = 1'b1;
        bus.send_data = 1'b0;
        bus.mosi_data = '0;
        bus.mstr      = 1'b1;
        bus.cpol      = 1'b1;
        bus.cpha      = 1'b0;
        bus.lsbfe     = 1'b0;
        bus.sppr      = 3'd0;
        bus.spr       = 3'd0;
        bus.spi_mode  = 2'b00;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_ss", bus.ss, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_tip", bus.tip, 0);
        chk("rst_rv", bus.receive_data, 0);
        chk("rst_miso_data", bus.miso_data, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge pclk);
        preset   = 1'b0;
        bus.cpol = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i], 0);
            wait_done(vecs[i].exp_lat + 50);
        end

        // Configuration and mstr changes mid-frame must not disturb timing or data.
        v = '{1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 8'h3E, 8'hD2, 8'hD2, 72};
        start_frame(v, 0);
        repeat (20) @(negedge pclk);
        bus.spr       = 3'd3;
        bus.sppr      = 3'd5;
        bus.cpha      = 1'b1;
        bus.lsbfe     = 1'b1;
        bus.cpol      = 1'b1;
        bus.mosi_data = 8'h00;
        bus.mstr      = 1'b0;
        wait_done(200);

        // Re-request during a frame is dropped.
        v = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h5C, 8'h77, 8'h77, 18};
        n0 = n_strobes;
        start_frame(v, 0);
        repeat (6) @(negedge pclk);
        bus.send_data = 1'b1;
        @(negedge pclk);
        bus.send_data = 1'b0;
        wait_done(60);
        repeat (25) @(negedge pclk);
        chk("one_strobe", n_strobes - n0, 1);

        // Requests with mstr=0 or spi_mode=stop are not accepted.
        bus.mstr      = 1'b0;
        bus.send_data = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk("nomstr_ss", bus.ss, 1);
            chk("nomstr_tip", bus.tip, 0);
        end
        bus.mstr     = 1'b1;
        bus.spi_mode = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("stop_idle_ss", bus.ss, 1);
        end
        bus.send_data = 1'b0;
        bus.spi_mode  = 2'b00;
        @(negedge pclk);
        chk("idle_state", dbg_state, 0);

        // Stop freeze for 20 cycles after edge 5.
        v = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hC6, 8'h1B, 8'h1B, 18};
        start_frame(v, 20);
        for (int i = 0; i < 60 && s_edges < 5; i++) @(negedge pclk);
        chk("reach_edge5", s_edges >= 5, 1);
        bus.spi_mode = 2'b10;
        snap_sclk = {7'd0, bus.sclk};
        snap_ss   = {7'd0, bus.ss};
        snap_mosi = {7'd0, bus.mosi};
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            chk("freeze_sclk", {7'd0, bus.sclk}, snap_sclk);
            chk("freeze_ss", {7'd0, bus.ss}, snap_ss);
            chk("freeze_mosi", {7'd0, bus.mosi}, snap_mosi);
            chk("freeze_tip", bus.tip, 1);
        end
        bus.spi_mode = 2'b00;
        wait_done(80);

        // Reset mid-frame discards the frame, then a normal frame follows.
        v = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h99, 8'h66, 8'h66, 18};
        start_frame(v, 0);
        for (int i = 0; i < 60 && s_edges < 9; i++) @(negedge pclk);
        chk("reach_edge9", s_edges >= 9, 1);
        preset = 1'b1;
        @(posedge pclk);
        #1;
        chk("midrst_ss", bus.ss, 1);
        chk("midrst_sclk", bus.sclk, 0);
        chk("midrst_tip", bus.tip, 0);
        chk("midrst_rv", bus.receive_data, 0);
        chk("midrst_miso_data", bus.miso_data, 0);
        @(negedge pclk);
        preset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        mosi_q.delete();
        n0 = n_strobes;
        repeat (30) @(negedge pclk);
        chk("no_strobe_after_rst", n_strobes - n0, 0);
        chk("miso_data_held", bus.miso_data, 0);
        v = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h4B, 8'hE1, 8'hE1, 18};
        start_frame(v, 0);
        wait_done(60);
        repeat (5) @(negedge pclk);
        chk("miso_data_hold", bus.miso_data, 8'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
